weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 113 +++++++++++
 tb/tb_weight_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader
// Description : Streams a counted run of source beats into consecutive
//               weight-memory words starting at a latched base address.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_loader #(
    parameter int AXI_HP_BIT = 64,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   beat_cnt,
    input  logic                  s_valid,
    input  logic [AXI_HP_BIT-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [AXI_HP_BIT-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0]            c_IDLE     = 2'd0;
    localparam logic [1:0]            c_LOAD     = 2'd1;
    localparam logic [1:0]            c_DONE     = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [ADDR_WIDTH:0]   r_last_idx;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [AXI_HP_BIT-1:0] r_wr_data;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_final;

    assign s_ready  = (r_state == c_LOAD);
    assign w_accept = s_valid & s_ready;
    assign w_final  = (r_idx == r_last_idx);
    assign busy     = (r_state != c_IDLE);
    // DONE is entered on the edge that registers the final write, so the pulse lines up with it.
    assign done     = (r_state == c_DONE);
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign err      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        if (beat_cnt == '0) begin
                            r_state <= c_DONE;
                        end else begin
                            r_addr     <= base_addr;
                            r_idx      <= '0;
                            r_last_idx <= beat_cnt - c_CNT_ONE;
                            r_state    <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= s_data;
                        r_addr    <= r_addr + c_ADDR_ONE;
                        r_idx     <= r_idx + c_CNT_ONE;
                        if (w_final) begin
                            r_state <= c_DONE;
                            if (!s_last) begin
                                r_err <= 1'b1;
                            end
                        end else if (s_last) begin
                            // Source ended the stream early: keep the beat, flag it, stop.
                            r_err   <= 1'b1;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// Directed self-checking bench for weight_loader; a negedge monitor logs
// accepts, writes and done pulses with cycle stamps for the scenario tasks.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] beat_cnt;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [63:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int rst_wr = 0;

    logic [13:0] wa[$];
    logic [63:0] wd[$];
    int          wc[$];
    int          ac[$];
    int          dc[$];

    weight_loader #(.AXI_HP_BIT(64), .ADDR_WIDTH(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .beat_cnt(beat_cnt), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (s_valid && s_ready) ac.push_back(cyc);
            if (wr_en) begin
                wa.push_back(wr_addr);
                wd.push_back(wr_data);
                wc.push_back(cyc);
            end
            if (done) dc.push_back(cyc);
        end else if (wr_en) begin
            rst_wr++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] pat(input int tag, input int k);
        logic [15:0] t;
        logic [15:0] kk;
        t  = tag[15:0];
        kk = k[15:0];
        return {16'hBEEF, t, 16'h0C0D, kk};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); ac.delete(); dc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; beat_cnt = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        tick(); tick();
        n_vec++; if ({wr_en, busy, done, err, s_ready} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b required 00000", {wr_en, busy, done, err, s_ready});
        end
        n_vec++; if (wr_addr !== 14'h0 || wr_data !== 64'h0) begin
            n_err++; $display("FAIL reset_bus: addr %h data %h required 0", wr_addr, wr_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clear_logs();
        base_addr = 14'h0010; beat_cnt = 15'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = pat(1, k); s_last = (k == 3);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick(); tick();
        n_vec++; if (wa.size() !== 4) begin
            n_err++; $display("FAIL basic_count: got %0d writes required 4", wa.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++; if (wa[k] !== 14'(16'h0010 + k) || wd[k] !== pat(1, k) || wc[k] !== ac[k] + 1) begin
                    n_err++; $display("FAIL basic_beat%0d: addr %h data %h cyc %0d required addr %h data %h cyc %0d",
                                      k, wa[k], wd[k], wc[k], 14'(16'h0010 + k), pat(1, k), ac[k] + 1);
                end
            end
            n_vec++; if (dc.size() !== 1 || dc[0] !== wc[3]) begin
                n_err++; $display("FAIL basic_done: got %0d pulses required 1 on cycle %0d", dc.size(), wc[3]);
            end
        end
        n_vec++; if (err !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_end: err %b busy %b required 0 0", err, busy);
        end
    endtask

    task automatic test_wrap();
        logic [13:0] exp_a [4];
        exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
        clear_logs();
        base_addr = 14'h3FFE; beat_cnt = 15'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = pat(2, k); s_last = (k == 3);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick(); tick();
        n_vec++; if (wa.size() !== 4) begin
            n_err++; $display("FAIL wrap_count: got %0d writes required 4", wa.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++; if (wa[k] !== exp_a[k]) begin
                    n_err++; $display("FAIL wrap_addr%0d: got %h required %h", k, wa[k], exp_a[k]);
                end
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [4:0] vpat;
        int         nb;
        vpat = 5'b10101;
        nb = 0;
        clear_logs();
        base_addr = 14'h0200; beat_cnt = 15'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_valid = vpat[4-k];
            s_data  = vpat[4-k] ? pat(3, nb) : 64'hDEAD_DEAD_DEAD_DEAD;
            s_last  = vpat[4-k] && (nb == 2);
            if (vpat[4-k]) nb++;
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick(); tick();
        n_vec++; if (wa.size() !== 3 || ac.size() !== 3) begin
            n_err++; $display("FAIL gaps_count: got %0d writes %0d accepts required 3 3", wa.size(), ac.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_vec++; if (wa[k] !== 14'(16'h0200 + k) || wd[k] !== pat(3, k) || wc[k] !== ac[k] + 1) begin
                    n_err++; $display("FAIL gaps_beat%0d: addr %h data %h cyc %0d required addr %h data %h cyc %0d",
                                      k, wa[k], wd[k], wc[k], 14'(16'h0200 + k), pat(3, k), ac[k] + 1);
                end
            end
        end
        n_vec++; if (err !== 1'b0 || dc.size() !== 1) begin
            n_err++; $display("FAIL gaps_end: err %b done pulses %0d required 0 1", err, dc.size());
        end
    endtask

    task automatic test_early_last();
        clear_logs();
        base_addr = 14'h0040; beat_cnt = 15'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = pat(4, k); s_last = (k == 1);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (wa.size() !== 2 || dc.size() !== 1) begin
            n_err++; $display("FAIL early_count: got %0d writes %0d done required 2 1", wa.size(), dc.size());
        end else begin
            n_vec++; if (wa[1] !== 14'h0041 || dc[0] !== wc[1]) begin
                n_err++; $display("FAIL early_last_write: addr %h done cyc %0d required 0041 cyc %0d", wa[1], dc[0], wc[1]);
            end
        end
        n_vec++; if (err !== 1'b1) begin
            n_err++; $display("FAIL early_err_hold: got %b required 1", err);
        end
        base_addr = 14'h0050; beat_cnt = 15'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++; if (err !== 1'b0 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL early_err_clear: err %b s_ready %b required 0 1", err, s_ready);
        end
        s_valid = 1'b1; s_data = pat(4, 9); s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        tick(); tick();
        n_vec++; if (wa.size() !== 3 || err !== 1'b0) begin
            n_err++; $display("FAIL early_reload: got %0d writes err %b required 3 0", wa.size(), err);
        end else begin
            n_vec++; if (wa[2] !== 14'h0050 || wd[2] !== pat(4, 9)) begin
                n_err++; $display("FAIL early_reload_write: addr %h data %h required 0050 %h", wa[2], wd[2], pat(4, 9));
            end
        end
    endtask

    task automatic test_final_no_last();
        clear_logs();
        base_addr = 14'h0060; beat_cnt = 15'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b1; s_data = pat(5, k); s_last = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        tick(); tick();
        n_vec++; if (wa.size() !== 2 || err !== 1'b1 || dc.size() !== 1) begin
            n_err++; $display("FAIL nolast: writes %0d err %b done %0d required 2 1 1", wa.size(), err, dc.size());
        end
    endtask

    task automatic test_zero_and_ignored();
        clear_logs();
        base_addr = 14'h0070; beat_cnt = 15'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++; if (done !== 1'b1 || busy !== 1'b1 || wr_en !== 1'b0 || s_ready !== 1'b0 || err !== 1'b0) begin
            n_err++; $display("FAIL zero_done: done %b busy %b wr_en %b s_ready %b err %b required 1 1 0 0 0",
                              done, busy, wr_en, s_ready, err);
        end
        tick();
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_idle: done %b busy %b required 0 0", done, busy);
        end
        base_addr = 14'h0080; beat_cnt = 15'd2; start = 1'b1;
        tick();
        base_addr = 14'h0090; beat_cnt = 15'd0;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = pat(6, 0); s_last = 1'b0;
        tick();
        s_data = pat(6, 1); s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        base_addr = 14'h00A0; beat_cnt = 15'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++; if (busy !== 1'b0) begin
            n_err++; $display("FAIL done_start_ignored: busy %b required 0", busy);
        end
        tick();
        n_vec++; if (wa.size() !== 2 || dc.size() !== 2) begin
            n_err++; $display("FAIL ignored_count: writes %0d done %0d required 2 2", wa.size(), dc.size());
        end else begin
            n_vec++; if (wa[0] !== 14'h0080 || wa[1] !== 14'h0081) begin
                n_err++; $display("FAIL ignored_addr: got %h %h required 0080 0081", wa[0], wa[1]);
            end
        end
    endtask

    task automatic test_reset_midload();
        clear_logs();
        base_addr = 14'h0100; beat_cnt = 15'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b1; s_data = pat(7, k); s_last = 1'b0;
            tick();
        end
        s_data = pat(7, 2);
        rst_n = 1'b0;
        #1;
        n_vec++; if ({wr_en, busy, done, err, s_ready} !== 5'b0 || wr_addr !== 14'h0 || wr_data !== 64'h0) begin
            n_err++; $display("FAIL midreset_outputs: flags %b addr %h data %h required 0",
                              {wr_en, busy, done, err, s_ready}, wr_addr, wr_data);
        end
        tick(); tick();
        rst_n = 1'b1;
        base_addr = 14'h0300; beat_cnt = 15'd2; start = 1'b1;
        s_valid = 1'b0;
        tick();
        start = 1'b0;
        n_vec++; if (s_ready !== 1'b1 || busy !== 1'b1 || rst_wr !== 0) begin
            n_err++; $display("FAIL midreset_restart: s_ready %b busy %b writes-in-reset %0d required 1 1 0",
                              s_ready, busy, rst_wr);
        end
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b1; s_data = pat(8, k); s_last = (k == 1);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick(); tick();
        n_vec++; if (wa.size() !== 3 || dc.size() !== 1 || err !== 1'b0) begin
            n_err++; $display("FAIL midreset_count: writes %0d done %0d err %b required 3 1 0", wa.size(), dc.size(), err);
        end else begin
            n_vec++; if (wa[0] !== 14'h0100 || wa[1] !== 14'h0300 || wa[2] !== 14'h0301 || wd[2] !== pat(8, 1)) begin
                n_err++; $display("FAIL midreset_addr: got %h %h %h required 0100 0300 0301", wa[0], wa[1], wa[2]);
            end
        end
    endtask

    task automatic test_full_count();
        int bad;
        bad = 0;
        clear_logs();
        base_addr = 14'h1234; beat_cnt = 15'h4000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16384; k++) begin
            s_valid = 1'b1; s_data = pat(9, k); s_last = (k == 16383);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick(); tick();
        n_vec++; if (wa.size() !== 16384 || dc.size() !== 1 || err !== 1'b0) begin
            n_err++; $display("FAIL full_count: writes %0d done %0d err %b required 16384 1 0", wa.size(), dc.size(), err);
        end else begin
            for (int i = 0; i < 16384; i++) begin
                if (wa[i] !== 14'(32'h1234 + i)) bad++;
            end
            n_vec++; if (bad !== 0) begin
                n_err++; $display("FAIL full_addr: %0d wrong addresses required 0", bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_valid_gaps();
        test_early_last();
        test_final_no_last();
        test_zero_and_ignored();
        test_reset_midload();
        test_full_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
